vga_digit_scheduler: RTL

//  Shares the on-screen digit-glyph slots between several requesters (counters, status

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_rr_arbiter.sv | 39 +++
 rtl/vga_digit_scheduler.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and scheduler types used by the display top level and the
// digit-slot scheduler.
package vga_pkg;

  localparam int COORD_W = 11;
  localparam int GLYPH_W = 4;

  // 640x480@60 horizontal timing (pixel counts).
  localparam int H_SYNC_END   = 96;
  localparam int H_BACK_END   = 144;
  localparam int H_ACTIVE_END = 784;
  localparam int H_TOTAL      = 800;

  // 640x480@60 vertical timing (line counts).
  localparam int V_SYNC_END   = 2;
  localparam int V_BACK_END   = 35;
  localparam int V_ACTIVE_END = 515;
  localparam int V_TOTAL      = 525;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_COMMIT = 1'b1
  } sched_state_t;

  // Frame boundary: vsync has just gone low.
  function automatic logic is_vs_fall(input logic vs_now, input logic vs_prev);
    return ~vs_now & vs_prev;
  endfunction

endpackage

// File: rtl/vga_rr_arbiter.sv
// Combinational round-robin arbiter: finds the first eligible requester at or after
// i_ptr (wrapping), where eligible means requesting and not masked.
module vga_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_mask,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [NUM_REQ-1:0]   w_elig;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;

  // Rotating a doubled copy puts the requester at i_ptr in bit 0.
  assign w_elig = i_req & ~i_mask;
  assign w_dbl  = {w_elig, w_elig};
  assign w_rot  = NUM_REQ'(w_dbl >> i_ptr);

  // Priority search over the rotated vector; descending loop so lowest offset wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_valid = 1'b1;
        if (int'(i_ptr) + k >= NUM_REQ) o_idx = IDX_W'(int'(i_ptr) + k - NUM_REQ);
        else                            o_idx = IDX_W'(int'(i_ptr) + k);
      end
    end
  end

  assign o_winner = o_valid ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/vga_digit_scheduler.sv
// Digit-glyph slot scheduler: arbitrates slot writes into a shadow bank and copies the
// shadow bank to the active bank at the vsync falling edge so glyphs never tear.
module vga_digit_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int COORD_W   = vga_pkg::COORD_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               vs,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*SLOT_W-1:0]          wr_slot,
  input  logic [NUM_REQ*vga_pkg::GLYPH_W-1:0] wr_num,
  input  logic [NUM_REQ*COORD_W-1:0]         wr_xoff,
  input  logic [NUM_REQ*COORD_W-1:0]         wr_yoff,
  input  logic [NUM_REQ*COORD_W-1:0]         wr_scale,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_SLOTS-1:0]               slot_en,
  output logic [NUM_SLOTS*vga_pkg::GLYPH_W-1:0] slot_num,
  output logic [NUM_SLOTS*COORD_W-1:0]       slot_xoff,
  output logic [NUM_SLOTS*COORD_W-1:0]       slot_yoff,
  output logic [NUM_SLOTS*COORD_W-1:0]       slot_scale,
  output logic                               frame_commit
);
  import vga_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_t       r_state, w_state_next;
  logic               r_vs_d, r_dirty, r_commit;
  logic [IDX_W-1:0]   r_rr_ptr, w_ptr_next;
  logic [NUM_REQ-1:0] r_gnt;
  logic               w_vs_fall, w_grant_en, w_commit_en;

  logic [NUM_REQ-1:0] w_win_onehot;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_win_valid;

  logic [SLOT_W-1:0]  w_win_slot;
  logic [GLYPH_W-1:0] w_win_num;
  logic [COORD_W-1:0] w_win_xoff, w_win_yoff, w_win_scale;

  logic               r_sh_en    [NUM_SLOTS];
  logic [GLYPH_W-1:0] r_sh_num   [NUM_SLOTS];
  logic [COORD_W-1:0] r_sh_xoff  [NUM_SLOTS];
  logic [COORD_W-1:0] r_sh_yoff  [NUM_SLOTS];
  logic [COORD_W-1:0] r_sh_scale [NUM_SLOTS];

  logic               r_act_en    [NUM_SLOTS];
  logic [GLYPH_W-1:0] r_act_num   [NUM_SLOTS];
  logic [COORD_W-1:0] r_act_xoff  [NUM_SLOTS];
  logic [COORD_W-1:0] r_act_yoff  [NUM_SLOTS];
  logic [COORD_W-1:0] r_act_scale [NUM_SLOTS];

  // A requester holding gnt is masked so one req level yields exactly one grant.
  vga_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req    (req),
    .i_mask   (r_gnt),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  assign w_vs_fall   = is_vs_fall(vs, r_vs_d);
  assign w_win_slot  = wr_slot [w_win_idx*SLOT_W  +: SLOT_W];
  assign w_win_num   = wr_num  [w_win_idx*GLYPH_W +: GLYPH_W];
  assign w_win_xoff  = wr_xoff [w_win_idx*COORD_W +: COORD_W];
  assign w_win_yoff  = wr_yoff [w_win_idx*COORD_W +: COORD_W];
  assign w_win_scale = wr_scale[w_win_idx*COORD_W +: COORD_W];
  assign w_ptr_next  = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ARB;
    else     r_state <= w_state_next;
  end

  // Next state: a frame edge with pending shadow writes forces one COMMIT cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ARB:    if (w_vs_fall && r_dirty) w_state_next = ST_COMMIT;
      ST_COMMIT: w_state_next = ST_ARB;
      default:   w_state_next = ST_ARB;
    endcase
  end

  // FSM outputs: grants are suppressed in the commit-entry cycle and in COMMIT itself.
  always_comb begin
    w_grant_en  = (r_state == ST_ARB) && w_win_valid && !(w_vs_fall && r_dirty);
    w_commit_en = (r_state == ST_COMMIT);
  end

  // Control registers: vsync delay, grant pulse, commit pulse, dirty flag, rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d   <= 1'b1;
      r_gnt    <= '0;
      r_commit <= 1'b0;
      r_dirty  <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_vs_d   <= vs;
      r_gnt    <= w_grant_en ? w_win_onehot : '0;
      r_commit <= w_commit_en;
      if (w_commit_en)     r_dirty <= 1'b0;
      else if (w_grant_en) r_dirty <= 1'b1;
      if (w_grant_en) r_rr_ptr <= w_ptr_next;
    end
  end

  // Shadow bank: the granted write lands here; a later write to the same slot overwrites.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_sh_en[i]    <= 1'b0;
        r_sh_num[i]   <= '0;
        r_sh_xoff[i]  <= '0;
        r_sh_yoff[i]  <= '0;
        r_sh_scale[i] <= '0;
      end
    end else if (w_grant_en) begin
      r_sh_en[w_win_slot]    <= (w_win_scale != '0);
      r_sh_num[w_win_slot]   <= w_win_num;
      r_sh_xoff[w_win_slot]  <= w_win_xoff;
      r_sh_yoff[w_win_slot]  <= w_win_yoff;
      r_sh_scale[w_win_slot] <= w_win_scale;
    end
  end

  // Active bank: takes the whole shadow bank in the COMMIT cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_act_en[i]    <= 1'b0;
        r_act_num[i]   <= '0;
        r_act_xoff[i]  <= '0;
        r_act_yoff[i]  <= '0;
        r_act_scale[i] <= '0;
      end
    end else if (w_commit_en) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_act_en[i]    <= r_sh_en[i];
        r_act_num[i]   <= r_sh_num[i];
        r_act_xoff[i]  <= r_sh_xoff[i];
        r_act_yoff[i]  <= r_sh_yoff[i];
        r_act_scale[i] <= r_sh_scale[i];
      end
    end
  end

  assign gnt          = r_gnt;
  assign frame_commit = r_commit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_out
      assign slot_en[gi]                         = r_act_en[gi];
      assign slot_num  [gi*GLYPH_W +: GLYPH_W]   = r_act_num[gi];
      assign slot_xoff [gi*COORD_W +: COORD_W]   = r_act_xoff[gi];
      assign slot_yoff [gi*COORD_W +: COORD_W]   = r_act_yoff[gi];
      assign slot_scale[gi*COORD_W +: COORD_W]   = r_act_scale[gi];
    end
  endgenerate

endmodule
